sram_req_ctrl: RTL

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

---
 rtl/sram_ctrl_pkg.sv | 8 +
 rtl/sram_rsp_fifo.sv | 34 +++
 rtl/sram_req_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared SRAM widths, response FIFO depth and controller state encoding
package sram_ctrl_pkg;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 10;
   localparam int WMASK_W = DATA_W / 8;
   localparam int RSP_DEPTH_DEF = 4;
   typedef enum logic [1:0] {ST_START = 2'd0, ST_INIT = 2'd1, ST_RUN = 2'd2} state_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: in-order read-response buffer with occupancy count
module sram_rsp_fifo #(
   parameter int W = 64,
   parameter int D = 4
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(D+1)-1:0] count
);
   localparam int PW = (D > 1) ? $clog2(D) : 1;
   localparam int CW = $clog2(D + 1);
   logic [W-1:0]  mem [D];
   logic [PW-1:0] wp, rp;
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < D; i++) mem[i] <= '0;
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp <= (wp == PW'(D - 1)) ? '0 : wp + 1'b1;
         end
         if (pop) rp <= (rp == PW'(D - 1)) ? '0 : rp + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   assign dout = mem[rp];
endmodule

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: clears the SRAM after reset, then serves posted writes and in-order credited reads
module sram_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_W,
   parameter int ADDR_WIDTH  = ADDR_W,
   parameter int WMASK_WIDTH = WMASK_W,
   parameter int RSP_DEPTH   = RSP_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [WMASK_WIDTH-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]  req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic                   init_done,
   output logic                   sram_ce,
   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int CRW = CW + 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
   state_t                st, st_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  rd_inflight, accept, pop;
   logic [CW-1:0]         fifo_count;
   logic [CRW-1:0]        credit;
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) st <= ST_START;
      else st <= st_nxt;
   end
   always_comb begin
      st_nxt = (st == ST_START) ? ST_INIT :
               (st == ST_INIT && init_cnt == ADDR_LAST) ? ST_RUN : st;
   end
   // A read occupies a credit from acceptance until its response is popped
   always_comb begin
      credit = {1'b0, fifo_count} + CRW'(rd_inflight);
      req_ready = (st == ST_RUN) && (credit < CRW'(RSP_DEPTH));
      accept = req_valid && req_ready;
      sram_ce = (st == ST_INIT) || accept;
      sram_we = (st == ST_INIT) || (accept && req_we);
      sram_wmask = (st == ST_INIT) ? '1 : req_wmask;
      sram_addr = (st == ST_INIT) ? init_cnt : req_addr;
      sram_din = (st == ST_INIT) ? '0 : req_wdata;
      rsp_valid = fifo_count != '0;
      pop = rsp_valid && rsp_ready;
   end
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         init_cnt <= '0;
         rd_inflight <= 1'b0;
         init_done <= 1'b0;
      end else begin
         if (st == ST_INIT) init_cnt <= init_cnt + 1'b1;
         rd_inflight <= accept && !req_we;
         init_done <= init_done || (st == ST_INIT && init_cnt == ADDR_LAST);
      end
   end
   sram_rsp_fifo #(.W(DATA_WIDTH), .D(RSP_DEPTH)) u_fifo (
      .clk(clk),
      .rstb(rstb),
      .push(rd_inflight),
      .pop(pop),
      .din(sram_dout),
      .dout(rsp_rdata),
      .count(fifo_count)
   );
endmodule
